// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_cfg
// Description : UART transmitter with an internal TX FIFO and a run-time
//               frame format: 5-8 data bits, optional even/odd parity,
//               1 or 2 stop bits and a programmable baud divisor.
//               Characters go out LSB-first and back-to-back for as long as
//               data is queued.
// Ports       : clk_i         system clock
//               rst_ni        asynchronous reset, active-low
//               baud_div_i    clocks per bit (0 and 1 both mean 1)
//               tx_en_i       allows new frames to start
//               data_bits_i   00=5, 01=6, 10=7, 11=8 data bits
//               parity_en_i   append a parity bit
//               parity_odd_i  1 = odd parity, 0 = even parity
//               stop2_i       1 = two stop bits
//               tx_we_i       push din_i into the FIFO
//               din_i         character to push
//               full_o        FIFO full
//               empty_o       FIFO empty
//               level_o       FIFO occupancy, 0..FIFO_DEPTH
//               busy_o        frame in progress
//               tx_bit_o      registered serial output, idle high
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_cfg #(
    parameter int FIFO_DEPTH = 32,
    parameter int BAUD_W     = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [BAUD_W-1:0]             baud_div_i,
    input  logic                          tx_en_i,
    input  logic [1:0]                    data_bits_i,
    input  logic                          parity_en_i,
    input  logic                          parity_odd_i,
    input  logic                          stop2_i,
    input  logic                          tx_we_i,
    input  logic [7:0]                    din_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          busy_o,
    output logic                          tx_bit_o
);

    localparam int                  c_ADDR_W   = $clog2(FIFO_DEPTH);
    localparam int                  c_LVL_W    = c_ADDR_W + 1;
    localparam logic [c_LVL_W-1:0]  c_FULL_LVL = c_LVL_W'(FIFO_DEPTH);
    localparam logic [c_LVL_W-1:0]  c_LVL_ONE  = c_LVL_W'(1);
    localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = c_ADDR_W'(1);
    localparam logic [BAUD_W-1:0]   c_DIV_ONE  = BAUD_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0]  r_level;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [7:0]          w_head;

    assign w_full  = (r_level == c_FULL_LVL);
    assign w_empty = (r_level == '0);
    // A pop in the same cycle frees a slot, so a push into a full FIFO is
    // still accepted when the transmitter takes the head at that edge.
    assign w_push  = tx_we_i && (!w_full || w_pop);
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LVL_ONE;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_LVL_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame sequencer
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [BAUD_W-1:0]   r_baud_cnt;
    logic [BAUD_W-1:0]   w_baud_nxt;
    logic [BAUD_W-1:0]   r_div;
    logic [2:0]          r_bit_cnt;
    logic [2:0]          w_bit_nxt;
    logic [7:0]          r_char;
    logic [7:0]          w_char_nxt;
    logic [1:0]          r_nbits;
    logic                r_par_en;
    logic                r_par_bit;
    logic                w_par_nxt;
    logic                r_stop2;
    logic                r_tx_bit;
    logic                w_tx_nxt;
    logic                w_load;
    logic                w_tick;
    logic                w_last_data;
    logic                w_last_stop;
    logic                w_can_start;
    logic [7:0]          w_mask;
    logic                w_head_par;

    assign w_tick      = (r_baud_cnt == (r_div - c_DIV_ONE));
    // Index of the last data bit is N-1 = data_bits + 4.
    assign w_last_data = (r_bit_cnt == ({1'b0, r_nbits} + 3'd4));
    assign w_last_stop = (r_bit_cnt == {2'b00, r_stop2});
    assign w_can_start = tx_en_i && !w_empty;

    always_comb begin
        w_mask = 8'hFF;
        case (data_bits_i)
            2'b00:   w_mask = 8'h1F;
            2'b01:   w_mask = 8'h3F;
            2'b10:   w_mask = 8'h7F;
            default: w_mask = 8'hFF;
        endcase
    end

    // Parity is computed once, from the head character and the live
    // configuration, at the moment the frame is loaded.
    assign w_head_par = (^(w_head & w_mask)) ^ parity_odd_i;

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_cnt;
        w_baud_nxt  = r_baud_cnt;
        w_load      = 1'b0;

        if (r_state != S_IDLE) begin
            w_baud_nxt = w_tick ? '0 : (r_baud_cnt + c_DIV_ONE);
        end

        case (r_state)
            S_IDLE: begin
                if (w_can_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                    w_baud_nxt  = '0;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (w_last_data) begin
                        w_bit_nxt   = 3'd0;
                        w_state_nxt = r_par_en ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = S_STOP;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (w_last_stop) begin
                        w_bit_nxt = 3'd0;
                        // Chain straight into the next frame when data is
                        // waiting so there is no idle cycle between frames.
                        if (w_can_start) begin
                            w_load      = 1'b1;
                            w_state_nxt = S_START;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_bit_nxt   = 3'd0;
                w_baud_nxt  = '0;
            end
        endcase
    end

    assign w_pop      = w_load;
    assign w_char_nxt = w_load ? w_head : r_char;
    assign w_par_nxt  = w_load ? w_head_par : r_par_bit;

    // The output register is loaded with the level of the bit that the
    // next state will transmit, so tx_bit_o lines up with busy_o.
    always_comb begin
        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_char_nxt[w_bit_nxt];
            S_PARITY: w_tx_nxt = w_par_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_div      <= c_DIV_ONE;
            r_char     <= 8'h00;
            r_nbits    <= 2'b00;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop2    <= 1'b0;
            r_tx_bit   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_char     <= w_char_nxt;
            r_par_bit  <= w_par_nxt;
            r_tx_bit   <= w_tx_nxt;
            if (w_load) begin
                r_nbits  <= data_bits_i;
                r_par_en <= parity_en_i;
                r_stop2  <= stop2_i;
                r_div    <= (baud_div_i == '0) ? c_DIV_ONE : baud_div_i;
            end
        end
    end

    assign full_o   = w_full;
    assign empty_o  = w_empty;
    assign level_o  = r_level;
    assign busy_o   = (r_state != S_IDLE);
    assign tx_bit_o = r_tx_bit;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_cfg
// Description : Self-checking bench for uart_tx_cfg. A waveform-level model
//               expands each queued character into its per-cycle line levels
//               and is compared against the DUT every cycle; directed tests
//               pin the model with hand-computed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_cfg;

    localparam int c_DEPTH = 32;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [15:0] baud_div_i = 16'd1;
    logic        tx_en_i = 1'b0;
    logic [1:0]  data_bits_i = 2'b11;
    logic        parity_en_i = 1'b0;
    logic        parity_odd_i = 1'b0;
    logic        stop2_i = 1'b0;
    logic        tx_we_i = 1'b0;
    logic [7:0]  din_i = 8'h00;
    logic        full_o;
    logic        empty_o;
    logic [5:0]  level_o;
    logic        busy_o;
    logic        tx_bit_o;

    int checks = 0;
    int failures = 0;

    uart_tx_cfg #(.FIFO_DEPTH(c_DEPTH), .BAUD_W(16)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .baud_div_i   (baud_div_i),
        .tx_en_i      (tx_en_i),
        .data_bits_i  (data_bits_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .stop2_i      (stop2_i),
        .tx_we_i      (tx_we_i),
        .din_i        (din_i),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .level_o      (level_o),
        .busy_o       (busy_o),
        .tx_bit_o     (tx_bit_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: FIFO as a queue, current frame as a queue of per-cycle levels
    // ------------------------------------------------------------------
    logic [7:0] mq[$];
    bit         wave[$];

    function automatic void build_frame(input logic [7:0] ch);
        int div = (baud_div_i == 16'd0) ? 1 : int'(baud_div_i);
        int n = int'(data_bits_i) + 5;
        bit p = 1'b0;
        bit seq[$];
        seq.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            seq.push_back(ch[i]);
            p ^= ch[i];
        end
        if (parity_en_i) seq.push_back(p ^ parity_odd_i);
        seq.push_back(1'b1);
        if (stop2_i) seq.push_back(1'b1);
        foreach (seq[k]) begin
            for (int r = 0; r < div; r++) wave.push_back(seq[k]);
        end
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mq.delete();
            wave.delete();
        end else begin
            int  pre_n;
            bit  popped;
            pre_n  = mq.size();
            popped = 1'b0;
            if (wave.size() > 0) void'(wave.pop_front());
            if (wave.size() == 0 && tx_en_i && pre_n > 0) begin
                build_frame(mq.pop_front());
                popped = 1'b1;
            end
            if (tx_we_i && (pre_n < c_DEPTH || popped)) mq.push_back(din_i);
        end
    end

    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("tx_bit", 32'(tx_bit_o), (wave.size() > 0) ? 32'(wave[0]) : 32'd1);
            check("busy",   32'(busy_o),   32'(wave.size() > 0));
            check("level",  32'(level_o),  32'(mq.size()));
            check("empty",  32'(empty_o),  32'(mq.size() == 0));
            check("full",   32'(full_o),   32'(mq.size() == c_DEPTH));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push(input logic [7:0] d);
        @(negedge clk_i);
        tx_we_i = 1'b1;
        din_i   = d;
        @(negedge clk_i);
        tx_we_i = 1'b0;
    endtask

    task automatic set_cfg(input logic [15:0] div, input logic [1:0] db,
                           input logic pen, input logic podd, input logic s2);
        @(negedge clk_i);
        baud_div_i   = div;
        data_bits_i  = db;
        parity_en_i  = pen;
        parity_odd_i = podd;
        stop2_i      = s2;
    endtask

    // Waits for busy_o, then samples each bit at mid-bit and counts busy
    // cycles over nb*div cycles. At cycle chg_at the mid-frame disturbance
    // (5 data bits, divisor 3, transmit disabled) is applied.
    task automatic capture(input int div, input int nb, input int chg_at,
                           output logic [31:0] bits, output int bcnt);
        int t = 0;
        bits = '0;
        bcnt = 0;
        while (!busy_o && t < 1000) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 1000) begin
            checks++;
            failures++;
            $display("FAIL frame_start_timeout actual=timeout required=busy");
        end
        for (int c = 0; c < nb * div; c++) begin
            if (c == chg_at) begin
                data_bits_i = 2'b00;
                baud_div_i  = 16'd3;
                tx_en_i     = 1'b0;
            end
            if ((c % div) == (div / 2)) bits[c / div] = tx_bit_o;
            if (busy_o) bcnt++;
            @(negedge clk_i);
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((!empty_o || busy_o) && t < 2000) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 2000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=timeout required=idle");
        end
    endtask

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] bits;
        int          bcnt;

        repeat (3) @(negedge clk_i);
        check("rst_tx",    32'(tx_bit_o), 32'd1);
        check("rst_busy",  32'(busy_o),   32'd0);
        check("rst_empty", 32'(empty_o),  32'd1);
        check("rst_full",  32'(full_o),   32'd0);
        check("rst_level", 32'(level_o),  32'd0);
        rst_ni = 1'b1;

        // 1: DIV=4, 8N1, 0xA5
        set_cfg(16'd4, 2'b11, 1'b0, 1'b0, 1'b0);
        tx_en_i = 1'b1;
        push(8'hA5);
        capture(4, 10, -1, bits, bcnt);
        check("t1_bits", bits[9:0], 32'b1101001010);
        check("t1_busy_cycles", 32'(bcnt), 32'd40);
        check("t1_idle_after", 32'(busy_o), 32'd0);

        // 2: DIV=2, 7E2 then 7O1, 0x35
        set_cfg(16'd2, 2'b10, 1'b1, 1'b0, 1'b1);
        push(8'h35);
        capture(2, 11, -1, bits, bcnt);
        check("t2_even_bits", bits[10:0], 32'b11001101010);
        check("t2_even_busy", 32'(bcnt), 32'd22);
        set_cfg(16'd2, 2'b10, 1'b1, 1'b1, 1'b0);
        push(8'h35);
        capture(2, 10, -1, bits, bcnt);
        check("t2_odd_bits", bits[9:0], 32'b1101101010);
        check("t2_odd_busy", 32'(bcnt), 32'd20);

        // 3: divisor 0 (acts as 1), 5N1, three back-to-back characters
        tx_en_i = 1'b0;
        set_cfg(16'd0, 2'b00, 1'b0, 1'b0, 1'b0);
        push(8'h1F);
        push(8'hE0);
        push(8'h15);
        check("t3_level3", 32'(level_o), 32'd3);
        tx_en_i = 1'b1;
        capture(1, 21, -1, bits, bcnt);
        check("t3_frame0", bits[6:0],   32'b1111110);
        check("t3_frame1", bits[13:7],  32'b1000000);
        check("t3_frame2", bits[20:14], 32'b1101010);
        check("t3_busy_contig", 32'(bcnt), 32'd21);
        check("t3_level0", 32'(level_o), 32'd0);

        // 4: fill FIFO with transmit disabled, overflow push, drain in order
        tx_en_i = 1'b0;
        set_cfg(16'd1, 2'b11, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        for (int i = 0; i < c_DEPTH + 1; i++) begin
            tx_we_i = 1'b1;
            din_i   = 8'((i * 7 + 1) & 8'hFF);
            @(negedge clk_i);
        end
        tx_we_i = 1'b0;
        check("t4_full", 32'(full_o), 32'd1);
        check("t4_level32", 32'(level_o), 32'd32);
        tx_en_i = 1'b1;
        capture(1, 10, -1, bits, bcnt);
        check("t4_first_char", bits[9:0], 32'b1000000010);
        wait_drain();

        // 5: mid-frame config change and disable
        tx_en_i = 1'b0;
        set_cfg(16'd2, 2'b11, 1'b0, 1'b0, 1'b0);
        push(8'hC3);
        push(8'h5A);
        tx_en_i = 1'b1;
        capture(2, 10, 5, bits, bcnt);
        check("t5_bits", bits[9:0], 32'b1110000110);
        check("t5_busy", 32'(bcnt), 32'd20);
        repeat (20) @(negedge clk_i);
        check("t5_no_start", 32'(busy_o), 32'd0);
        check("t5_level1", 32'(level_o), 32'd1);

        // 6: async reset mid data bit, then clean restart
        set_cfg(16'd4, 2'b11, 1'b0, 1'b0, 1'b0);
        push(8'h00);
        tx_en_i = 1'b1;
        repeat (14) @(negedge clk_i);
        check("t6_pre_tx_low", 32'(tx_bit_o), 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_rst_tx", 32'(tx_bit_o), 32'd1);
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        check("t6_rst_empty", 32'(empty_o), 32'd1);
        check("t6_rst_level", 32'(level_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        push(8'hA5);
        capture(4, 10, -1, bits, bcnt);
        check("t6_restart_bits", bits[9:0], 32'b1101001010);
        check("t6_restart_busy", 32'(bcnt), 32'd40);

        repeat (5) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
